// File: rtl/accum_datapath_pkg.sv
// Shared constants for the accumulator datapath: data width and common-bus
// source encodings.
package accum_datapath_pkg;

  localparam int unsigned DATA_W = 16;

  typedef enum logic [2:0] {
    BUS_ENTRY = 3'd0,
    BUS_AR    = 3'd1,
    BUS_PC    = 3'd2,
    BUS_DR    = 3'd3,
    BUS_AC    = 3'd4,
    BUS_IR    = 3'd5,
    BUS_ZERO  = 3'd6,
    BUS_MEM   = 3'd7
  } bus_sel_e;

endpackage

// File: rtl/accum_datapath_dec.sv
// 3-to-8 one-hot decoder with enable; all outputs low when disabled.
module dec_3to8_en (
  input  logic       en,
  input  logic [2:0] sel,
  output logic [7:0] y
);

  always_comb begin
    y = '0;
    if (en) y[sel] = 1'b1;
  end

endmodule

// File: rtl/accum_datapath.sv
// Accumulator-side datapath: ALU, AC/E registers, common-bus source mux and
// the timing/opcode decoders of the 16-bit teaching CPU.
module accum_datapath
  import accum_datapath_pkg::*;
#(
  parameter logic [DATA_W-1:0] ENTRY_POINT = 16'h0010
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              ac_ld,
  input  logic              ac_clr,
  input  logic              ac_inr,
  input  logic              op_and,
  input  logic              op_add,
  input  logic              op_dr,
  input  logic              op_inpr,
  input  logic              op_cmp,
  input  logic              op_shr,
  input  logic              op_shl,
  input  logic              e_clr,
  input  logic              e_cmp,
  input  logic [DATA_W-1:0] dr,
  input  logic [7:0]        inpr,
  input  logic [11:0]       ar,
  input  logic [11:0]       pc,
  input  logic [DATA_W-1:0] ir,
  input  logic [DATA_W-1:0] mem_data,
  input  logic [2:0]        bus_sel,
  input  logic [2:0]        sc,
  input  logic              dec_en,
  output logic [DATA_W-1:0] ac,
  output logic              e,
  output logic [DATA_W-1:0] ac_nxt,
  output logic              e_nxt,
  output logic [DATA_W-1:0] bus_data,
  output logic [7:0]        t,
  output logic [7:0]        d
);

  logic [DATA_W:0] sum;

  assign sum = {1'b0, ac} + {1'b0, dr};

  // First active strobe wins; no strobe passes AC through unchanged.
  always_comb begin
    ac_nxt = ac;
    if      (op_and)  ac_nxt = ac & dr;
    else if (op_add)  ac_nxt = sum[DATA_W-1:0];
    else if (op_dr)   ac_nxt = dr;
    else if (op_inpr) ac_nxt = {ac[15:8], inpr};
    else if (op_cmp)  ac_nxt = ~ac;
    else if (op_shr)  ac_nxt = {e, ac[15:1]};
    else if (op_shl)  ac_nxt = {ac[14:0], e};
  end

  always_comb begin
    e_nxt = e;
    if      (e_clr)  e_nxt = 1'b0;
    else if (e_cmp)  e_nxt = ~e;
    else if (op_shr) e_nxt = ac[0];
    else if (op_shl) e_nxt = ac[15];
    else if (op_add) e_nxt = sum[DATA_W];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ac <= '0;
      e  <= 1'b0;
    end else if (en) begin
      e <= e_nxt;
      if      (ac_clr) ac <= '0;
      else if (ac_ld)  ac <= ac_nxt;
      else if (ac_inr) ac <= ac + 16'd1;
    end
  end

  always_comb begin
    bus_data = '0;
    case (bus_sel_e'(bus_sel))
      BUS_ENTRY: bus_data = ENTRY_POINT;
      BUS_AR:    bus_data = {4'b0, ar};
      BUS_PC:    bus_data = {4'b0, pc};
      BUS_DR:    bus_data = dr;
      BUS_AC:    bus_data = ac;
      BUS_IR:    bus_data = ir;
      BUS_ZERO:  bus_data = '0;
      BUS_MEM:   bus_data = mem_data;
      default:   bus_data = '0;
    endcase
  end

  dec_3to8_en u_dec_t (
    .en  (dec_en),
    .sel (sc),
    .y   (t)
  );

  dec_3to8_en u_dec_d (
    .en  (dec_en),
    .sel (ir[14:12]),
    .y   (d)
  );

endmodule

// File: tb/tb_accum_datapath.sv
// Directed self-checking bench for accum_datapath.
module tb_accum_datapath;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        ac_ld, ac_clr, ac_inr;
  logic        op_and, op_add, op_dr, op_inpr, op_cmp, op_shr, op_shl;
  logic        e_clr, e_cmp;
  logic [15:0] dr;
  logic [7:0]  inpr;
  logic [11:0] ar, pc;
  logic [15:0] ir, mem_data;
  logic [2:0]  bus_sel, sc;
  logic        dec_en;
  logic [15:0] ac, ac_nxt, bus_data;
  logic        e, e_nxt;
  logic [7:0]  t, d;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  always #5 clk = ~clk;

  accum_datapath #(.ENTRY_POINT(16'h0010)) dut (
    .clk(clk), .rst_n(rst_n), .en(en),
    .ac_ld(ac_ld), .ac_clr(ac_clr), .ac_inr(ac_inr),
    .op_and(op_and), .op_add(op_add), .op_dr(op_dr), .op_inpr(op_inpr),
    .op_cmp(op_cmp), .op_shr(op_shr), .op_shl(op_shl),
    .e_clr(e_clr), .e_cmp(e_cmp),
    .dr(dr), .inpr(inpr), .ar(ar), .pc(pc), .ir(ir), .mem_data(mem_data),
    .bus_sel(bus_sel), .sc(sc), .dec_en(dec_en),
    .ac(ac), .e(e), .ac_nxt(ac_nxt), .e_nxt(e_nxt),
    .bus_data(bus_data), .t(t), .d(d)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic clear_strobes();
    {ac_ld, ac_clr, ac_inr} = '0;
    {op_and, op_add, op_dr, op_inpr, op_cmp, op_shr, op_shl} = '0;
    {e_clr, e_cmp} = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    clear_strobes();
  endtask

  task automatic load_ac(input logic [15:0] v);
    dr = v; op_dr = 1'b1; ac_ld = 1'b1;
    tick();
  endtask

  task automatic set_e(input logic b);
    e_clr = 1'b1;
    tick();
    if (b) begin
      e_cmp = 1'b1;
      tick();
    end
  endtask

  logic [15:0] bus_exp [8];

  initial begin
    bus_exp[0] = 16'h0010; bus_exp[1] = 16'h0ABC;
    bus_exp[2] = 16'h0123; bus_exp[3] = 16'h1111;
    bus_exp[4] = 16'h2222; bus_exp[5] = 16'h7333;
    bus_exp[6] = 16'h0000; bus_exp[7] = 16'h4444;

    clear_strobes();
    rst_n = 1'b0; en = 1'b1;
    dr = '0; inpr = '0; ar = '0; pc = '0; ir = '0; mem_data = '0;
    bus_sel = '0; sc = '0; dec_en = 1'b0;
    #12 rst_n = 1'b1;
    check("rst_ac", 32'(ac), 32'h0);
    check("rst_e", 32'(e), 32'h0);

    // Asynchronous reset mid-cycle from a nonzero state
    load_ac(16'h1234);
    set_e(1'b1);
    check("pre_rst_ac", 32'(ac), 32'h1234);
    check("pre_rst_e", 32'(e), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_ac", 32'(ac), 32'h0);
    check("async_rst_e", 32'(e), 32'h0);
    #1 rst_n = 1'b1;

    // ADD with carry out
    load_ac(16'hFFFF);
    dr = 16'h0001; op_add = 1'b1; ac_ld = 1'b1;
    #1;
    check("add_ac_nxt", 32'(ac_nxt), 32'h0000);
    check("add_e_nxt", 32'(e_nxt), 32'h1);
    tick();
    check("add_carry_ac", 32'(ac), 32'h0000);
    check("add_carry_e", 32'(e), 32'h1);
    load_ac(16'h0002);
    dr = 16'h0003; op_add = 1'b1; ac_ld = 1'b1;
    tick();
    check("add_ac", 32'(ac), 32'h0005);
    check("add_e", 32'(e), 32'h0);

    // Shifts through E
    load_ac(16'h8001);
    set_e(1'b0);
    op_shr = 1'b1; ac_ld = 1'b1;
    tick();
    check("shr_ac", 32'(ac), 32'h4000);
    check("shr_e", 32'(e), 32'h1);
    op_shl = 1'b1; ac_ld = 1'b1;
    tick();
    check("shl_ac", 32'(ac), 32'h8001);
    check("shl_e", 32'(e), 32'h0);

    // INPR into low byte
    load_ac(16'hAB00);
    inpr = 8'h5C; op_inpr = 1'b1; ac_ld = 1'b1;
    tick();
    check("inpr_ac", 32'(ac), 32'hAB5C);

    // AND and complement
    dr = 16'h0FF0; op_and = 1'b1; ac_ld = 1'b1;
    tick();
    check("and_ac", 32'(ac), 32'h0B50);
    op_cmp = 1'b1; ac_ld = 1'b1;
    tick();
    check("cmp_ac", 32'(ac), 32'hF4AF);

    // Priority: clear beats load; E clear beats complement
    dr = 16'h5555; op_dr = 1'b1; ac_clr = 1'b1; ac_ld = 1'b1;
    tick();
    check("clr_over_ld", 32'(ac), 32'h0);
    set_e(1'b1);
    e_clr = 1'b1; e_cmp = 1'b1;
    tick();
    check("eclr_over_ecmp", 32'(e), 32'h0);

    // Increment wraps and leaves E alone
    load_ac(16'hFFFF);
    set_e(1'b1);
    ac_inr = 1'b1;
    tick();
    check("inr_wrap_ac", 32'(ac), 32'h0);
    check("inr_e_hold", 32'(e), 32'h1);

    // Stop mode freezes both registers
    load_ac(16'h1234);
    en = 1'b0;
    dr = 16'h5555; op_dr = 1'b1; ac_ld = 1'b1; e_cmp = 1'b1;
    tick();
    check("en0_ac", 32'(ac), 32'h1234);
    check("en0_e", 32'(e), 32'h1);
    en = 1'b1;

    // Bus source sweep
    load_ac(16'h2222);
    ar = 12'hABC; pc = 12'h123; dr = 16'h1111; ir = 16'h7333; mem_data = 16'h4444;
    for (int i = 0; i < 8; i++) begin
      bus_sel = 3'(i);
      #1;
      check($sformatf("bus_sel%0d", i), 32'(bus_data), 32'(bus_exp[i]));
    end

    // Decoders
    dec_en = 1'b1; sc = 3'd5; ir = 16'h7800;
    #1;
    check("t_sc5", 32'(t), 32'h20);
    check("d_op7", 32'(d), 32'h80);
    sc = 3'd0; ir = 16'h0000;
    #1;
    check("t_sc0", 32'(t), 32'h01);
    check("d_op0", 32'(d), 32'h01);
    dec_en = 1'b0; sc = 3'd3; ir = 16'h3000;
    #1;
    check("t_dis", 32'(t), 32'h00);
    check("d_dis", 32'(d), 32'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/accum_datapath.md
Name: accum_datapath

Overview:
- Accumulator-side datapath of the basic 16-bit teaching CPU.
- Contents:
  - ALU computing the next AC/E values.
  - AC and E registers.
  - 8-way common-bus source multiplexer.
  - Two 3-to-8 one-hot decoders: timing t from SC, opcode d from IR[14:12].
- The control-logic block drives all strobes. This block only computes, selects and holds AC/E.

Parameters:
- ENTRY_POINT, 16'h0010, constant placed on the bus for bus_sel=0.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- en  in  1  register update enable; 0 freezes AC and E (stop mode)
- ac_ld  in  1  load AC from ALU result
- ac_clr  in  1  clear AC
- ac_inr  in  1  increment AC
- op_and, op_add, op_dr, op_inpr, op_cmp, op_shr, op_shl  in  1 each  ALU function strobes
- e_clr, e_cmp  in  1 each  E clear / complement
- dr  in  16  data register
- inpr  in  8  input register
- ar, pc  in  12 each  address register, program counter
- ir  in  16  instruction register
- mem_data  in  16  memory read data
- bus_sel  in  3  bus source select
- sc  in  3  sequence counter
- dec_en  in  1  decoder enable
- ac  out  16  accumulator
- e  out  1  carry/extend flag
- ac_nxt  out  16  combinational ALU result
- e_nxt  out  1  combinational next E
- bus_data  out  16  common bus
- t  out  8  one-hot timing decode of sc
- d  out  8  one-hot opcode decode of ir[14:12]

Behaviour:
- Reset: rst_n=0 asynchronously forces ac=16'h0000 and e=0. All other outputs are combinational.

ALU (combinational). ac_nxt uses the first active strobe in this order; if none is active, ac_nxt=ac.
- op_and: ac & dr
- op_add: ac + dr, low 16 bits
- op_dr: dr
- op_inpr: {ac[15:8], inpr}
- op_cmp: ~ac
- op_shr: {e, ac[15:1]}
- op_shl: {ac[14:0], e}

e_nxt uses the first active condition in this order:
- e_clr: 0
- e_cmp: ~e
- op_shr: ac[0]
- op_shl: ac[15]
- op_add: carry out of ac+dr (bit 16)
- otherwise: e

AC register, at the rising clk edge when en=1, first active control wins:
- ac_clr: 0
- ac_ld: ac_nxt
- ac_inr: ac+1, wraps 16'hFFFF to 0; E is unaffected by INC
- otherwise: hold

E register:
- e <= e_nxt every edge when en=1.
- en=0 holds both AC and E regardless of strobes.

Bus (combinational), selected by bus_sel:
- 0: ENTRY_POINT
- 1: {4'b0, ar}
- 2: {4'b0, pc}
- 3: dr
- 4: ac
- 5: ir
- 6: 16'h0000
- 7: mem_data

Decoders:
- t[k]=1 iff sc==k and dec_en=1.
- d[k]=1 iff ir[14:12]==k and dec_en=1.
- dec_en=0 drives all bits 0.
- Both are exactly one-hot when enabled.

Other requirements:
- All results are available the same cycle (zero latency). AC/E update one edge later.
- Reset has priority over en and every strobe. Reset assertion mid-cycle clears AC/E immediately.

Decomposition:
- Shared package holds:
  - bus-select encodings: BUS_ENTRY=0, BUS_AR=1, BUS_PC=2, BUS_DR=3, BUS_AC=4, BUS_IR=5, BUS_ZERO=6, BUS_MEM=7.
  - Data width constant 16.
- One sub-module is natural: dec_3to8_en (enable input, 3-bit in, 8-bit one-hot out), instantiated twice.
- ALU and bus mux stay inline.

Test Plan:
- Reset with ac preloaded 16'h1234, e=1 → after rst_n low, ac=0 and e=0 immediately.
- op_add+ac_ld, ac=16'hFFFF, dr=16'h0001 → ac=16'h0000, e=1. Repeat with ac=16'h0002, dr=16'h0003 → ac=16'h0005, e=0.
- ac=16'h8001, e=0:
  - op_shr+ac_ld → ac=16'h4000, e=1.
  - then op_shl+ac_ld → ac=16'h8001, e=0.
- op_inpr+ac_ld, ac=16'hAB00, inpr=8'h5C → ac=16'hAB5C.
- Strobe priority and INC:
  - ac_clr+ac_ld together → ac=0.
  - e_clr+e_cmp with e=1 → e=0.
  - ac_inr at 16'hFFFF → 0, e unchanged.
  - en=0 with ac_ld → ac unchanged.
- Sweep bus_sel 0..7 with ar=12'hABC, pc=12'h123, dr=16'h1111, ac=16'h2222, ir=16'h7333, mem_data=16'h4444 → bus_data:
  - 0 → 16'h0010
  - 1 → 16'h0ABC
  - 2 → 16'h0123
  - 3 → 16'h1111
  - 4 → 16'h2222
  - 5 → 16'h7333
  - 6 → 16'h0000
  - 7 → 16'h4444
- Decoders:
  - sc=5 → t=8'h20.
  - ir=16'h7800 → d=8'h80.
  - dec_en=0 → t=d=8'h00.
